// File: rtl/fetch_controller_pkg.sv
// Shared types, widths and the PC legality check for the instruction fetch controller.
package fetch_controller_pkg;

  localparam int unsigned INSTR_WIDTH = 32;
  localparam int unsigned ADDR_WIDTH  = 64;
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {
    FETCH = 1'b0,
    FAULT = 1'b1
  } fetch_state_e;

  // Highest legal word-aligned byte address for a memory of imem_words words.
  function automatic logic [ADDR_WIDTH-1:0] pc_last(input int unsigned imem_words);
    return ADDR_WIDTH'(imem_words) * ADDR_WIDTH'(4) - ADDR_WIDTH'(4);
  endfunction

  // Word aligned and inside memory, compared over the full 64-bit address.
  function automatic logic pc_legal(input logic [ADDR_WIDTH-1:0] pc,
                                    input int unsigned imem_words);
    return (pc[1:0] == 2'b00) && (pc <= pc_last(imem_words));
  endfunction

endpackage

// File: rtl/fetch_controller_if.sv
// Fetch-side bus: run gate, instruction memory port, redirect input, decode handshake and status.
interface fetch_controller_if;
  import fetch_controller_pkg::*;

  logic                   run;
  logic [ADDR_WIDTH-1:0]  imem_address;
  logic [INSTR_WIDTH-1:0] imem_instr;
  logic                   redirect_valid;
  logic [ADDR_WIDTH-1:0]  redirect_pc;
  logic                   if_valid;
  logic                   if_ready;
  logic [INSTR_WIDTH-1:0] if_instr;
  logic [ADDR_WIDTH-1:0]  if_pc;
  logic                   fault;
  logic [ADDR_WIDTH-1:0]  fault_pc;
  logic [63:0]            fetch_count;

  modport master (
    input  run, imem_instr, redirect_valid, redirect_pc, if_ready,
    output imem_address, if_valid, if_instr, if_pc, fault, fault_pc, fetch_count
  );

  modport slave (
    output run, imem_instr, redirect_valid, redirect_pc, if_ready,
    input  imem_address, if_valid, if_instr, if_pc, fault, fault_pc, fetch_count
  );

endinterface

// File: rtl/fetch_controller_out_reg.sv
// Holding register presenting one instruction and its PC to decode; load wins over flush.
module fetch_out_reg
  import fetch_controller_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_load,
  input  logic                   i_flush,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic                   o_valid,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [ADDR_WIDTH-1:0]  o_pc
);

  logic                   r_valid;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0]  r_pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, reads the external instruction memory and
// presents instructions to decode, handling redirects, back-pressure, run gating and faults.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           IMEM_WORDS = 32
) (
  input  logic               clk,
  input  logic               reset,
  fetch_controller_if.master bus
);

  fetch_state_e          r_state;
  fetch_state_e          w_state_next;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [ADDR_WIDTH-1:0] r_fault_pc;
  logic [ADDR_WIDTH-1:0] w_fault_pc_next;
  logic [63:0]           r_fetch_count;

  logic                   w_if_valid;
  logic [INSTR_WIDTH-1:0] w_if_instr;
  logic [ADDR_WIDTH-1:0]  w_if_pc;
  logic                   w_load;
  logic                   w_flush;

  logic w_take;
  logic w_slot_free;
  logic w_pc_ok;
  logic w_redir_ok;

  assign w_take      = w_if_valid & bus.if_ready;
  assign w_slot_free = ~w_if_valid | w_take;
  assign w_pc_ok     = pc_legal(r_pc, IMEM_WORDS);
  assign w_redir_ok  = pc_legal(bus.redirect_pc, IMEM_WORDS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FAULT is absorbing; only reset leaves it.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH: begin
        if (bus.redirect_valid) begin
          if (!w_redir_ok) w_state_next = FAULT;
        end else if (!w_pc_ok) begin
          w_state_next = FAULT;
        end
      end
      FAULT:   w_state_next = FAULT;
      default: w_state_next = FETCH;
    endcase
  end

  always_comb begin
    w_load          = 1'b0;
    w_flush         = 1'b0;
    w_pc_next       = r_pc;
    w_fault_pc_next = r_fault_pc;
    case (r_state)
      FETCH: begin
        if (bus.redirect_valid) begin
          w_flush = 1'b1;
          if (w_redir_ok) w_pc_next = bus.redirect_pc;
          else            w_fault_pc_next = bus.redirect_pc;
        end else if (!w_pc_ok) begin
          // An untaken instruction stays presented into FAULT.
          w_fault_pc_next = r_pc;
          w_flush         = w_take;
        end else if (bus.run && w_slot_free) begin
          w_load    = 1'b1;
          w_pc_next = r_pc + ADDR_WIDTH'(4);
        end else if (w_take) begin
          w_flush = 1'b1;
        end
      end
      FAULT:   w_flush = w_take;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_fault_pc    <= '0;
      r_fetch_count <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_fault_pc <= w_fault_pc_next;
      if (w_take) r_fetch_count <= r_fetch_count + 64'd1;
    end
  end

  fetch_out_reg u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_flush (w_flush),
    .i_instr (bus.imem_instr),
    .i_pc    (r_pc),
    .o_valid (w_if_valid),
    .o_instr (w_if_instr),
    .o_pc    (w_if_pc)
  );

  assign bus.imem_address = r_pc;
  assign bus.if_valid     = w_if_valid;
  assign bus.if_instr     = w_if_instr;
  assign bus.if_pc        = w_if_pc;
  assign bus.fault        = (r_state == FAULT);
  assign bus.fault_pc     = r_fault_pc;
  assign bus.fetch_count  = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a 32-word instance and a 4-word instance for run-off-the-end.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  fetch_controller_if bus ();
  fetch_controller_if bus4 ();

  fetch_controller #(.RESET_PC(64'h0), .IMEM_WORDS(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_controller #(.RESET_PC(64'h0), .IMEM_WORDS(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  always #5 clk = ~clk;

  // Word i of memory holds 32'hC000_0000 | i.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a < 64'd128) ? (32'hC000_0000 | 32'(a[6:2])) : 32'hDEAD_BEEF;
  endfunction

  always_comb bus.imem_instr  = mem_word(bus.imem_address);
  always_comb bus4.imem_instr = mem_word(bus4.imem_address);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b1;  bus.if_ready = 1'b1;  bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;
    bus4.run = 1'b0; bus4.if_ready = 1'b1; bus4.redirect_valid = 1'b0; bus4.redirect_pc = '0;

    // Reset state and back-to-back stream
    tick();
    check("rst_valid", 64'(bus.if_valid), 64'd0);
    check("rst_instr", 64'(bus.if_instr), 64'd0);
    check("rst_ifpc",  bus.if_pc, 64'd0);
    check("rst_addr",  bus.imem_address, 64'd0);
    check("rst_count", bus.fetch_count, 64'd0);
    check("rst_fault", 64'(bus.fault), 64'd0);
    check("rst_fpc",   bus.fault_pc, 64'd0);
    reset = 1'b0;
    tick();
    check("b2b_valid0", 64'(bus.if_valid), 64'd1);
    check("b2b_pc0",    bus.if_pc, 64'h0);
    check("b2b_ins0",   64'(bus.if_instr), 64'hC000_0000);
    tick();
    check("b2b_pc1",  bus.if_pc, 64'h4);
    check("b2b_ins1", 64'(bus.if_instr), 64'hC000_0001);
    tick();
    check("b2b_pc2",  bus.if_pc, 64'h8);
    check("b2b_ins2", 64'(bus.if_instr), 64'hC000_0002);
    tick();
    check("b2b_pc3",  bus.if_pc, 64'hC);
    check("b2b_ins3", 64'(bus.if_instr), 64'hC000_0003);
    check("b2b_cnt3", bus.fetch_count, 64'd3);
    tick();
    check("b2b_cnt4", bus.fetch_count, 64'd4);
    check("b2b_pc4",  bus.if_pc, 64'h10);

    // Back-pressure at if_pc=8
    reset = 1'b1; tick(); reset = 1'b0;
    tick(); tick(); tick();
    check("bp_pc8", bus.if_pc, 64'h8);
    bus.if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", 64'(bus.if_valid), 64'd1);
      check("bp_hold_pc",    bus.if_pc, 64'h8);
      check("bp_hold_ins",   64'(bus.if_instr), 64'hC000_0002);
      check("bp_hold_addr",  bus.imem_address, 64'hC);
      check("bp_hold_cnt",   bus.fetch_count, 64'd2);
    end
    bus.if_ready = 1'b1;
    tick();
    check("bp_next_pc",  bus.if_pc, 64'hC);
    check("bp_next_ins", 64'(bus.if_instr), 64'hC000_0003);
    check("bp_next_cnt", bus.fetch_count, 64'd3);

    // Redirect to 0x40 while 0x10 is presented and taken
    tick();
    check("rd_pre_pc", bus.if_pc, 64'h10);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h40;
    tick();
    bus.redirect_valid = 1'b0;
    check("rd_flush",  64'(bus.if_valid), 64'd0);
    check("rd_cnt",    bus.fetch_count, 64'd5);
    check("rd_addr",   bus.imem_address, 64'h40);
    tick();
    check("rd_valid",  64'(bus.if_valid), 64'd1);
    check("rd_pc",     bus.if_pc, 64'h40);
    check("rd_ins",    64'(bus.if_instr), 64'hC000_0010);
    check("rd_cnt2",   bus.fetch_count, 64'd5);

    // Misaligned redirect faults; later redirects ignored
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h42;
    tick();
    check("mis_fault", 64'(bus.fault), 64'd1);
    check("mis_fpc",   bus.fault_pc, 64'h42);
    check("mis_valid", 64'(bus.if_valid), 64'd0);
    check("mis_cnt",   bus.fetch_count, 64'd6);
    check("mis_addr",  bus.imem_address, 64'h44);
    bus.redirect_pc = 64'h8;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    check("ign_fault", 64'(bus.fault), 64'd1);
    check("ign_fpc",   bus.fault_pc, 64'h42);
    check("ign_addr",  bus.imem_address, 64'h44);
    check("ign_valid", 64'(bus.if_valid), 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    check("clr_fault", 64'(bus.fault), 64'd0);
    check("clr_fpc",   bus.fault_pc, 64'd0);
    check("clr_addr",  bus.imem_address, 64'd0);
    tick();
    check("rs_valid",  64'(bus.if_valid), 64'd1);
    check("rs_pc",     bus.if_pc, 64'h0);

    // Redirect to last legal word, then fall off the end at 0x80
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h7C;
    tick();
    bus.redirect_valid = 1'b0;
    check("end_nofault", 64'(bus.fault), 64'd0);
    tick();
    check("end_pc",    bus.if_pc, 64'h7C);
    check("end_ins",   64'(bus.if_instr), 64'hC000_001F);
    tick();
    check("end_fault", 64'(bus.fault), 64'd1);
    check("end_fpc",   bus.fault_pc, 64'h80);
    check("end_valid", 64'(bus.if_valid), 64'd0);

    // Upper address bits count in the range check
    reset = 1'b1; tick(); reset = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h1_0000_0000;
    tick();
    bus.redirect_valid = 1'b0;
    check("hi_fault", 64'(bus.fault), 64'd1);
    check("hi_fpc",   bus.fault_pc, 64'h1_0000_0000);

    // Four-word instance runs off the end
    reset = 1'b1; tick(); reset = 1'b0;
    bus.run = 1'b0;
    bus4.run = 1'b1;
    tick(); tick(); tick(); tick();
    check("w4_pc12",   bus4.if_pc, 64'hC);
    check("w4_ins12",  64'(bus4.if_instr), 64'hC000_0003);
    check("w4_nof",    64'(bus4.fault), 64'd0);
    tick();
    check("w4_fault",  64'(bus4.fault), 64'd1);
    check("w4_fpc",    bus4.fault_pc, 64'h10);
    check("w4_valid",  64'(bus4.if_valid), 64'd0);
    check("w4_cnt",    bus4.fetch_count, 64'd4);
    tick();
    check("w4_nowrap", bus4.imem_address, 64'h10);
    check("w4_valid2", 64'(bus4.if_valid), 64'd0);
    bus4.run = 1'b0;

    // run=0 mid-stream, then reset while if_valid=1
    reset = 1'b1; tick(); reset = 1'b0;
    bus.run = 1'b1;
    tick(); tick();
    check("ro_pc4", bus.if_pc, 64'h4);
    bus.run = 1'b0;
    tick();
    check("ro_drop",  64'(bus.if_valid), 64'd0);
    check("ro_addr",  bus.imem_address, 64'h8);
    check("ro_cnt",   bus.fetch_count, 64'd2);
    tick();
    check("ro_frz",   bus.imem_address, 64'h8);
    bus.run = 1'b1; bus.if_ready = 1'b0;
    tick();
    check("ro_resume_valid", 64'(bus.if_valid), 64'd1);
    check("ro_resume_pc",    bus.if_pc, 64'h8);
    reset = 1'b1;
    tick();
    check("mr_valid", 64'(bus.if_valid), 64'd0);
    check("mr_cnt",   bus.fetch_count, 64'd0);
    check("mr_addr",  bus.imem_address, 64'd0);
    check("mr_ifpc",  bus.if_pc, 64'd0);
    check("mr_ins",   64'(bus.if_instr), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
